// File: rtl/sfm_cast_out_pipe.sv
// sfm_cast_out_pipe: pipelined float-to-integer output caster for the softmax
// datapath. Every FP lane of a stream beat becomes a signed or unsigned
// fixed-point integer with configurable integer bits. Rounding is truncate or
// RNE, results saturate, and specials are handled. NUM_REGS elastic stages
// (0..4) sit behind the cast; with 0 stages the path is combinational.
//
// The input FP format is given as exponent/mantissa widths (FP_EXP_W and
// FP_MAN_W; the default 8/7 is BF16). The payload is the low DATA_WIDTH-32
// bits of each beat. ctrl_i and rnd_mode_i are applied during the input
// handshake cycle, so each beat carries its own settings.
//
// Optional build macro: SFM_CAST_OUT_SAT_CNT_EN. When it is defined, each lane
// carries a saturation flag through the pipeline. sat_cnt_o then counts the
// flagged lanes of emitted beats and sticks at 0xFFFF_FFFF. Without the macro,
// sat_cnt_o is tied to 0.
//
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   clear_i           synchronous flush of all stages and of the counter
//   ctrl_i            {enable, is_signed, int_bits}
//   rnd_mode_i        0 = truncate toward zero, 1 = round-to-nearest-even
//   stream_i_*        sink: data, strb, valid, ready
//   stream_o_*        source: data, strb, valid, ready
//   sat_cnt_o         saturated-lane counter
//
// Handshake: a beat transfers on a rising edge where valid & ready are both
// high. A source holds valid and data stable until that transfer. ready may
// depend combinationally on downstream ready, but never on valid.

package sfm_cast_out_pkg;
  typedef struct packed {
    logic       enable;
    logic       is_signed;
    logic [7:0] int_bits;
  } cast_ctrl_t;
endpackage

module sfm_cast_out_pipe
  import sfm_cast_out_pkg::*;
#(
  parameter int DATA_WIDTH = 96,
  parameter int FP_EXP_W   = 8,
  parameter int FP_MAN_W   = 7,
  parameter int INT_WIDTH  = 8,
  parameter int NUM_REGS   = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  cast_ctrl_t              ctrl_i,
  input  logic                    rnd_mode_i,
  input  logic [DATA_WIDTH-1:0]   stream_i_data,
  input  logic [DATA_WIDTH/8-1:0] stream_i_strb,
  input  logic                    stream_i_valid,
  output logic                    stream_i_ready,
  output logic [DATA_WIDTH-1:0]   stream_o_data,
  output logic [DATA_WIDTH/8-1:0] stream_o_strb,
  output logic                    stream_o_valid,
  input  logic                    stream_o_ready,
  output logic [31:0]             sat_cnt_o
);

  localparam int ACTUAL_DW = DATA_WIDTH - 32;
  localparam int FP_WIDTH  = 1 + FP_EXP_W + FP_MAN_W;
  localparam int NUM_LANES = ACTUAL_DW / FP_WIDTH;
  localparam int STRB_W    = DATA_WIDTH / 8;
  localparam int FP_B      = FP_WIDTH / 8;
  localparam int INT_B     = INT_WIDTH / 8;
  localparam int BIAS      = (1 << (FP_EXP_W - 1)) - 1;
  // MW holds a significand shifted left by up to INT_WIDTH, plus headroom.
  localparam int MW        = FP_MAN_W + INT_WIDTH + 3;
  // TW holds the significand followed by guard and sticky space for right shifts.
  localparam int TW        = 2 * FP_MAN_W + 3;

  // Casts one lane. Returns {sat, result}.
  function automatic logic [INT_WIDTH:0] cast_lane(
    input logic [FP_WIDTH-1:0] fp,
    input logic                is_signed,
    input logic [7:0]          int_bits,
    input logic                rnd
  );
    logic                sgn;
    logic [FP_EXP_W-1:0] ex;
    logic [FP_MAN_W-1:0] mn;
    logic [FP_MAN_W:0]   sig;
    logic [FP_MAN_W:0]   kept;
    logic [TW-1:0]       t;
    logic [MW-1:0]       mag;
    logic [MW-1:0]       lim_pos;
    logic [MW-1:0]       lim_neg;
    logic                guard;
    logic                sticky;
    logic                big;
    logic                sat;
    logic [INT_WIDTH-1:0] res;
    int                  f;
    int                  sh;
    int                  rs;
    sgn     = fp[FP_WIDTH-1];
    ex      = fp[FP_WIDTH-2 -: FP_EXP_W];
    mn      = fp[FP_MAN_W-1:0];
    sig     = {1'b1, mn};
    kept    = '0;
    t       = '0;
    mag     = '0;
    guard   = 1'b0;
    sticky  = 1'b0;
    big     = 1'b0;
    sat     = 1'b0;
    res     = '0;
    sh      = 0;
    rs      = 0;
    f       = INT_WIDTH - int'(is_signed) - int'(int_bits);
    lim_pos = (MW'(1) << (INT_WIDTH - int'(is_signed))) - MW'(1);
    lim_neg = MW'(1) << (INT_WIDTH - 1);
    if (&ex) begin
      // inf saturates toward its sign; NaN collapses to 0. Both are flagged.
      sat = 1'b1;
      if (mn == '0) begin
        if (!sgn)           res = lim_pos[INT_WIDTH-1:0];
        else if (is_signed) res = lim_neg[INT_WIDTH-1:0];
      end
    end else if (ex != '0) begin
      // Subnormals and zero fall through with res = 0.
      sh = int'(ex) - BIAS + f - FP_MAN_W;
      if (sh >= 0) begin
        if (sh > INT_WIDTH) big = 1'b1;
        else                mag = MW'(sig) << sh;
      end else begin
        rs = -sh;
        if (rs > FP_MAN_W + 2) begin
          // Value is below 1/4 ulp of the result: no rounding up is possible.
          sticky = 1'b1;
        end else begin
          t      = {sig, {(FP_MAN_W + 2){1'b0}}} >> rs;
          kept   = t[TW-1 -: FP_MAN_W + 1];
          guard  = t[FP_MAN_W+1];
          sticky = |t[FP_MAN_W:0];
        end
        // The rounding carry may reach the next power of two; the clamp below sees it.
        mag = MW'(kept) + MW'(rnd & guard & (sticky | kept[0]));
      end
      if (sgn) begin
        if (!is_signed) begin
          sat = 1'b1;
        end else if (big || mag > lim_neg) begin
          res = lim_neg[INT_WIDTH-1:0];
          sat = 1'b1;
        end else begin
          res = INT_WIDTH'(MW'(0) - mag);
        end
      end else if (big || mag > lim_pos) begin
        res = lim_pos[INT_WIDTH-1:0];
        sat = 1'b1;
      end else begin
        res = mag[INT_WIDTH-1:0];
      end
    end
    return {sat, res};
  endfunction

  logic [DATA_WIDTH-1:0] cast_data;
  logic [STRB_W-1:0]     cast_strb;
  logic                  lane_strb;
`ifdef SFM_CAST_OUT_SAT_CNT_EN
  logic [NUM_LANES-1:0]  cast_flags;
  logic [NUM_LANES-1:0]  out_flags;
  logic [INT_WIDTH:0]    lane_r;
`endif

  always_comb begin
    cast_data = stream_i_data;
    cast_strb = stream_i_strb;
    lane_strb = 1'b0;
`ifdef SFM_CAST_OUT_SAT_CNT_EN
    cast_flags = '0;
    lane_r     = '0;
`endif
    if (ctrl_i.enable) begin
      cast_data = '0;
      cast_strb = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        lane_strb = &stream_i_strb[l*FP_B +: FP_B];
`ifdef SFM_CAST_OUT_SAT_CNT_EN
        lane_r = cast_lane(stream_i_data[l*FP_WIDTH +: FP_WIDTH], ctrl_i.is_signed,
                           ctrl_i.int_bits, rnd_mode_i);
        cast_data[l*INT_WIDTH +: INT_WIDTH] = lane_r[INT_WIDTH-1:0];
        cast_flags[l] = lane_r[INT_WIDTH] & lane_strb;
`else
        cast_data[l*INT_WIDTH +: INT_WIDTH] =
          INT_WIDTH'(cast_lane(stream_i_data[l*FP_WIDTH +: FP_WIDTH], ctrl_i.is_signed,
                               ctrl_i.int_bits, rnd_mode_i));
`endif
        cast_strb[l*INT_B +: INT_B] = {INT_B{lane_strb}};
      end
    end
  end

  if (NUM_REGS == 0) begin : g_comb
    assign stream_i_ready = stream_o_ready;
    assign stream_o_valid = stream_i_valid;
    assign stream_o_data  = cast_data;
    assign stream_o_strb  = cast_strb;
`ifdef SFM_CAST_OUT_SAT_CNT_EN
    assign out_flags = cast_flags;
`endif
  end else begin : g_pipe
    logic [NUM_REGS-1:0]   v;
    logic [NUM_REGS-1:0]   in_v;
    logic [NUM_REGS:0]     rdy;
    logic [DATA_WIDTH-1:0] d    [NUM_REGS];
    logic [DATA_WIDTH-1:0] in_d [NUM_REGS];
    logic [STRB_W-1:0]     s    [NUM_REGS];
    logic [STRB_W-1:0]     in_s [NUM_REGS];
`ifdef SFM_CAST_OUT_SAT_CNT_EN
    logic [NUM_LANES-1:0]  fl    [NUM_REGS];
    logic [NUM_LANES-1:0]  in_fl [NUM_REGS];
`endif

    // A stage can take a new beat when it is empty or its own beat moves on.
    always_comb begin
      rdy[NUM_REGS] = stream_o_ready;
      for (int i = NUM_REGS - 1; i >= 0; i--) rdy[i] = ~v[i] | rdy[i+1];
      in_v[0] = stream_i_valid;
      in_d[0] = cast_data;
      in_s[0] = cast_strb;
`ifdef SFM_CAST_OUT_SAT_CNT_EN
      in_fl[0] = cast_flags;
`endif
      for (int i = 1; i < NUM_REGS; i++) begin
        in_v[i] = v[i-1];
        in_d[i] = d[i-1];
        in_s[i] = s[i-1];
`ifdef SFM_CAST_OUT_SAT_CNT_EN
        in_fl[i] = fl[i-1];
`endif
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        v <= '0;
        for (int i = 0; i < NUM_REGS; i++) begin
          d[i] <= '0;
          s[i] <= '0;
`ifdef SFM_CAST_OUT_SAT_CNT_EN
          fl[i] <= '0;
`endif
        end
      end else begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (clear_i)     v[i] <= 1'b0;
          else if (rdy[i]) v[i] <= in_v[i];
          if (rdy[i] && in_v[i]) begin
            d[i] <= in_d[i];
            s[i] <= in_s[i];
`ifdef SFM_CAST_OUT_SAT_CNT_EN
            fl[i] <= in_fl[i];
`endif
          end
        end
      end
    end

    assign stream_i_ready = rdy[0] & ~clear_i;
    assign stream_o_valid = v[NUM_REGS-1];
    assign stream_o_data  = d[NUM_REGS-1];
    assign stream_o_strb  = s[NUM_REGS-1];
`ifdef SFM_CAST_OUT_SAT_CNT_EN
    assign out_flags = fl[NUM_REGS-1];
`endif
  end

`ifdef SFM_CAST_OUT_SAT_CNT_EN
  logic [31:0] sat_cnt_q;
  logic [31:0] flag_pop;
  logic [32:0] cnt_sum;

  always_comb begin
    flag_pop = '0;
    for (int l = 0; l < NUM_LANES; l++) flag_pop = flag_pop + 32'(out_flags[l]);
    cnt_sum = {1'b0, sat_cnt_q} + {1'b0, flag_pop};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                            sat_cnt_q <= '0;
    else if (clear_i)                       sat_cnt_q <= '0;
    else if (stream_o_valid && stream_o_ready)
      sat_cnt_q <= cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
  end

  assign sat_cnt_o = sat_cnt_q;
`else
  assign sat_cnt_o = '0;
`endif

endmodule

// File: tb/tb_sfm_cast_out_pipe.sv
// Directed bench for sfm_cast_out_pipe (BF16 -> INT8, four lanes, two stages).
module tb_sfm_cast_out_pipe;
  import sfm_cast_out_pkg::*;

  localparam int DW  = 96;
  localparam int SW  = DW / 8;
  localparam int NR  = 2;
  localparam int EW  = SW + DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  cast_ctrl_t    ctrl = '0;
  logic          rnd = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [SW-1:0] in_strb = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic [SW-1:0] out_strb;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   sat_cnt;

  logic [EW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            out_cnt  = 0;
  int            exp_cnt  = 0;

  sfm_cast_out_pipe #(
    .DATA_WIDTH(DW), .FP_EXP_W(8), .FP_MAN_W(7), .INT_WIDTH(8), .NUM_REGS(NR)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .ctrl_i(ctrl), .rnd_mode_i(rnd),
    .stream_i_data(in_data), .stream_i_strb(in_strb), .stream_i_valid(in_valid),
    .stream_i_ready(in_ready), .stream_o_data(out_data), .stream_o_strb(out_strb),
    .stream_o_valid(out_valid), .stream_o_ready(out_ready), .sat_cnt_o(sat_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic cast_ctrl_t mk(input logic en, input logic sg, input logic [7:0] ib);
    cast_ctrl_t c;
    c.enable    = en;
    c.is_signed = sg;
    c.int_bits  = ib;
    return c;
  endfunction

  function automatic logic [31:0] exp_sat(input int n);
`ifdef SFM_CAST_OUT_SAT_CNT_EN
    return 32'(n);
`else
    return 32'(n & 0);
`endif
  endfunction

  // scoreboard: every accepted output beat must match the head of exp_q
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      out_cnt++;
      if (exp_q.size() == 0) check("sb_beat_expected", EW'(exp_q.size()), EW'(1));
      else                   check("beat", {out_strb, out_data}, exp_q.pop_front());
    end
  end

  // driver: call at #1 after a rising edge; returns at #1 after the transfer edge
  task automatic send_beat(input logic [DW-1:0] d, input logic [SW-1:0] s, input cast_ctrl_t c,
                           input logic r, input logic push, input logic [DW-1:0] ed,
                           input logic [SW-1:0] es, input int sat);
    int   waited = 0;
    logic ok = 1'b0;
    in_data  = d;
    in_strb  = s;
    ctrl     = c;
    rnd      = r;
    in_valid = 1'b1;
    while (!ok && waited < 200) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else          waited++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!ok) check("hs_timeout", EW'(ok), EW'(1));
    if (ok && push) begin
      exp_q.push_back({es, ed});
      exp_cnt += sat;
    end
  endtask

  task automatic drain();
    int waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    #1;
    if (exp_q.size() != 0) check("drain_timeout", EW'(exp_q.size()), EW'(0));
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", EW'(out_valid), EW'(0));
    check("rst_out_data",  EW'(out_data),  EW'(0));
    check("rst_out_strb",  EW'(out_strb),  EW'(0));
    check("rst_sat_cnt",   EW'(sat_cnt),   EW'(0));
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;

    // cast vectors, back to back
    send_beat({32'hDEADBEEF, 16'h7F80, 16'h3F80, 16'hBF00, 16'h3F00}, 12'hFFF, mk(1, 1, 0), 1,
              1, {64'h0, 32'h7F7FC040}, 12'h00F, 2);
    send_beat({32'h0, 16'h0001, 16'h7FC0, 16'hBF00, 16'h3F80}, 12'hFFF, mk(1, 0, 0), 0,
              1, {64'h0, 32'h000000FF}, 12'h00F, 3);
    send_beat({32'h0, 16'hBC40, 16'h3C40, 16'h3B80, 16'h3BC0}, 12'hFFF, mk(1, 1, 0), 1,
              1, {64'h0, 32'hFE020001}, 12'h00F, 0);
    send_beat({32'h0, 16'hBC40, 16'h3C40, 16'h3B80, 16'h3BC0}, 12'hFFF, mk(1, 1, 0), 0,
              1, {64'h0, 32'hFF010000}, 12'h00F, 0);
    send_beat(96'h0123_4567_89AB_CDEF_FEDC_BA98, 12'hA5C, mk(0, 1, 0), 1,
              1, 96'h0123_4567_89AB_CDEF_FEDC_BA98, 12'hA5C, 0);
    send_beat({32'h0, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80}, 12'hFFB, mk(1, 1, 0), 1,
              1, {64'h0, 32'h7F7F7F7F}, 12'h00D, 3);
    send_beat({32'h0, 16'hC030, 16'h0000, 16'hFF80, 16'h4030}, 12'hFFF, mk(1, 1, 3), 1,
              1, {64'h0, 32'hD400802C}, 12'h00F, 1);
    send_beat({32'h0, 16'hC000, 16'hBF7F, 16'hBF80, 16'h3F7F}, 12'hFFF, mk(1, 1, 0), 1,
              1, {64'h0, 32'h8080807F}, 12'h00F, 2);
    send_beat({32'h0, 16'h3D80, 16'h4300, 16'hFF80, 16'h4130}, 12'hFFF, mk(1, 0, 4), 0,
              1, {64'h0, 32'h01FF00B0}, 12'h00F, 2);
    drain();
    repeat (2) @(posedge clk);
    #1;
    check("sat_cnt_vectors", EW'(sat_cnt), EW'(exp_sat(exp_cnt)));

    // latency with the pipe idle and output ready
    in_data  = 96'hAAAA_5555_0F0F_F0F0_1234_5678;
    in_strb  = 12'hFFF;
    ctrl     = mk(0, 0, 0);
    in_valid = 1'b1;
    @(negedge clk);
    check("lat_in_ready", EW'(in_ready), EW'(1));
    exp_q.push_back({12'hFFF, 96'hAAAA_5555_0F0F_F0F0_1234_5678});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_cycle1_valid", EW'(out_valid), EW'(0));
    @(negedge clk);
    check("lat_cycle2_valid", EW'(out_valid), EW'(1));
    drain();

    // stall: output not ready for 5 edges while 10 beats stream in
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    out_cnt   = 0;
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          logic [DW-1:0] pd;
          pd = DW'(k + 1) * 96'h0001_0203_0405_0607_0809_0A0B;
          send_beat(pd, 12'hFFF, mk(0, 0, 0), 0, 1, pd, 12'hFFF, 0);
        end
      end
      begin
        repeat (5) @(negedge clk);
        check("stall_in_ready", EW'(in_ready), EW'(0));
        check("stall_out_valid", EW'(out_valid), EW'(1));
        check("stall_held", EW'(exp_q.size()), EW'(2));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("stall_beat_count", EW'(out_cnt), EW'(10));

    // clear with two beats in flight
    send_beat({32'h0, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80}, 12'hFFF, mk(1, 1, 0), 1,
              1, {64'h0, 32'h7F7F7F7F}, 12'h00F, 4);
    drain();
    #10;
    check("sat_cnt_pre_clear", EW'(sat_cnt), EW'(exp_sat(exp_cnt)));
    out_ready = 1'b0;
    send_beat(96'h1, 12'hFFF, mk(0, 0, 0), 0, 0, '0, '0, 0);
    send_beat(96'h2, 12'hFFF, mk(0, 0, 0), 0, 0, '0, '0, 0);
    clear    = 1'b1;
    in_data  = 96'h3;
    in_valid = 1'b1;
    @(negedge clk);
    check("clear_in_ready", EW'(in_ready), EW'(0));
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    exp_cnt  = 0;
    check("clear_out_valid", EW'(out_valid), EW'(0));
    check("clear_sat_cnt", EW'(sat_cnt), EW'(0));
    out_ready = 1'b1;
    out_cnt   = 0;
    repeat (5) @(posedge clk);
    #1;
    check("clear_no_output", EW'(out_cnt), EW'(0));

    // asynchronous reset mid-stream
    send_beat({32'h0, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80}, 12'hFFF, mk(1, 1, 0), 1,
              1, {64'h0, 32'h7F7F7F7F}, 12'h00F, 4);
    drain();
    #10;
    check("sat_cnt_pre_reset", EW'(sat_cnt), EW'(exp_sat(exp_cnt)));
    out_ready = 1'b0;
    send_beat(96'h4, 12'hFFF, mk(0, 0, 0), 0, 0, '0, '0, 0);
    send_beat(96'h5, 12'hFFF, mk(0, 0, 0), 0, 0, '0, '0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", EW'(out_valid), EW'(0));
    check("arst_out_data", EW'(out_data), EW'(0));
    check("arst_sat_cnt", EW'(sat_cnt), EW'(0));
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    out_cnt   = 0;
    repeat (5) @(posedge clk);
    #1;
    check("arst_no_output", EW'(out_cnt), EW'(0));

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
